// File: rtl/reg_wr_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : reg_wr_arbiter_if                                            |
// | Description : Requester handshakes and register-file write port of the     |
// |               write-port arbiter. REG_WR_ARB_STATS_EN adds the statistics  |
// |               counter outputs and their clear input.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reg_wr_arbiter_if;
    logic        cpu_valid;
    logic [3:0]  cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        a1_valid;
    logic [3:0]  a1_addr;
    logic [15:0] a1_data;
    logic        a1_ready;
    logic        a2_valid;
    logic [3:0]  a2_addr;
    logic [15:0] a2_data;
    logic        a2_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wp_err;
    logic        starve_pre;
`ifdef REG_WR_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cpu;
    logic [15:0] stat_a1;
    logic [15:0] stat_a2;
    logic [15:0] stat_pre;
`endif

    modport slave (
        input  cpu_valid, cpu_addr, cpu_data,
        input  a1_valid, a1_addr, a1_data,
        input  a2_valid, a2_addr, a2_data,
        output cpu_ready, a1_ready, a2_ready,
        output wr_en, wr_addr, wr_data, wp_err, starve_pre
`ifdef REG_WR_ARB_STATS_EN
        ,
        input  stat_clr,
        output stat_cpu, stat_a1, stat_a2, stat_pre
`endif
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_data,
        output a1_valid, a1_addr, a1_data,
        output a2_valid, a2_addr, a2_data,
        input  cpu_ready, a1_ready, a2_ready,
        input  wr_en, wr_addr, wr_data, wp_err, starve_pre
`ifdef REG_WR_ARB_STATS_EN
        ,
        output stat_clr,
        input  stat_cpu, stat_a1, stat_a2, stat_pre
`endif
    );
endinterface

`default_nettype wire

// File: rtl/reg_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : reg_wr_arbiter                                               |
// | Description : Shares the register-file write port between CPU writeback    |
// |               (strict priority) and two round-robin aux requesters with    |
// |               starvation preemption. Optional macro REG_WR_ARB_STATS_EN    |
// |               adds per-source transfer and preemption counters.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_wr_arbiter #(
    parameter int          STARVE_LIMIT = 8,
    parameter int          SW           = 4,
    parameter logic [15:0] WP_MASK      = 16'h0001
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    reg_wr_arbiter_if.slave bus
);

    localparam logic [1:0]    c_G_NONE  = 2'd0;
    localparam logic [1:0]    c_G_CPU   = 2'd1;
    localparam logic [1:0]    c_G_A1    = 2'd2;
    localparam logic [1:0]    c_G_A2    = 2'd3;
    localparam bit            c_PRE_EN  = (STARVE_LIMIT != 0);
    localparam logic [SW-1:0] c_LIMIT   = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] c_CNT_MAX = '1;

    logic          r_rr_a2;
    logic [SW-1:0] r_cnt1;
    logic [SW-1:0] r_cnt2;
    logic          r_wr_en;
    logic [3:0]    r_wr_addr;
    logic [15:0]   r_wr_data;
    logic          r_wp_err;
    logic          r_starve_pre;

    logic          w_st1;
    logic          w_st2;
    logic          w_pre;
    logic [1:0]    w_gnt;
    logic [3:0]    w_addr;
    logic [15:0]   w_data;
    logic          w_xfer;
    logic          w_aux;
    logic          w_zero;
    logic          w_wp;

    always_comb begin
        w_st1 = c_PRE_EN && bus.a1_valid && (r_cnt1 >= c_LIMIT);
        w_st2 = c_PRE_EN && bus.a2_valid && (r_cnt2 >= c_LIMIT);
        w_gnt = c_G_NONE;
        w_pre = 1'b0;
        if (w_st1 && w_st2) begin
            w_gnt = r_rr_a2 ? c_G_A2 : c_G_A1;
            w_pre = 1'b1;
        end else if (w_st1) begin
            w_gnt = c_G_A1;
            w_pre = 1'b1;
        end else if (w_st2) begin
            w_gnt = c_G_A2;
            w_pre = 1'b1;
        end else if (bus.cpu_valid) begin
            w_gnt = c_G_CPU;
        end else if (bus.a1_valid && bus.a2_valid) begin
            w_gnt = r_rr_a2 ? c_G_A2 : c_G_A1;
        end else if (bus.a1_valid) begin
            w_gnt = c_G_A1;
        end else if (bus.a2_valid) begin
            w_gnt = c_G_A2;
        end
    end

    always_comb begin
        w_addr = 4'd0;
        w_data = 16'd0;
        case (w_gnt)
            c_G_CPU: begin w_addr = bus.cpu_addr; w_data = bus.cpu_data; end
            c_G_A1:  begin w_addr = bus.a1_addr;  w_data = bus.a1_data;  end
            c_G_A2:  begin w_addr = bus.a2_addr;  w_data = bus.a2_data;  end
            default: begin w_addr = 4'd0;         w_data = 16'd0;        end
        endcase
    end

    assign w_xfer = (w_gnt != c_G_NONE);
    assign w_aux  = w_gnt[1];
    assign w_zero = (w_addr == 4'd0);
    assign w_wp   = w_aux && WP_MASK[w_addr];

    assign bus.cpu_ready = rst_n && (w_gnt == c_G_CPU);
    assign bus.a1_ready  = rst_n && (w_gnt == c_G_A1);
    assign bus.a2_ready  = rst_n && (w_gnt == c_G_A2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_a2      <= 1'b0;
            r_cnt1       <= '0;
            r_cnt2       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 4'd0;
            r_wr_data    <= 16'd0;
            r_wp_err     <= 1'b0;
            r_starve_pre <= 1'b0;
        end else begin
            // Pointer always lands on the aux that was not just served.
            if (w_gnt == c_G_A1) begin
                r_rr_a2 <= 1'b1;
            end else if (w_gnt == c_G_A2) begin
                r_rr_a2 <= 1'b0;
            end

            if ((w_gnt == c_G_A1) || !bus.a1_valid) begin
                r_cnt1 <= '0;
            end else if (r_cnt1 != c_CNT_MAX) begin
                r_cnt1 <= r_cnt1 + SW'(1);
            end

            if ((w_gnt == c_G_A2) || !bus.a2_valid) begin
                r_cnt2 <= '0;
            end else if (r_cnt2 != c_CNT_MAX) begin
                r_cnt2 <= r_cnt2 + SW'(1);
            end

            r_wr_en      <= w_xfer && !w_zero && !w_wp;
            r_wp_err     <= w_xfer && !w_zero && w_wp;
            r_starve_pre <= w_pre && bus.cpu_valid;
            if (w_xfer) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wp_err     = r_wp_err;
    assign bus.starve_pre = r_starve_pre;

`ifdef REG_WR_ARB_STATS_EN
    logic [15:0] r_stat_cpu;
    logic [15:0] r_stat_a1;
    logic [15:0] r_stat_a2;
    logic [15:0] r_stat_pre;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cpu <= 16'd0;
            r_stat_a1  <= 16'd0;
            r_stat_a2  <= 16'd0;
            r_stat_pre <= 16'd0;
        end else if (bus.stat_clr) begin
            r_stat_cpu <= 16'd0;
            r_stat_a1  <= 16'd0;
            r_stat_a2  <= 16'd0;
            r_stat_pre <= 16'd0;
        end else begin
            if (w_gnt == c_G_CPU) r_stat_cpu <= sat_inc(r_stat_cpu);
            if (w_gnt == c_G_A1)  r_stat_a1  <= sat_inc(r_stat_a1);
            if (w_gnt == c_G_A2)  r_stat_a2  <= sat_inc(r_stat_a2);
            if (w_pre && bus.cpu_valid) r_stat_pre <= sat_inc(r_stat_pre);
        end
    end

    assign bus.stat_cpu = r_stat_cpu;
    assign bus.stat_a1  = r_stat_a1;
    assign bus.stat_a2  = r_stat_a2;
    assign bus.stat_pre = r_stat_pre;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_wr_arbiter                                            |
// | Description : Randomized scoreboard bench for reg_wr_arbiter with a        |
// |               behavioural grant model.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_wr_arbiter;
    localparam int          LIMIT = 8;
    localparam int          SWB   = 4;
    localparam logic [15:0] WPM   = 16'h0009;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_wr_arbiter_if bus();

    reg_wr_arbiter #(.STARVE_LIMIT(LIMIT), .SW(SWB), .WP_MASK(WPM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        en;
        logic [3:0]  a;
        logic [15:0] d;
        logic        wp;
        logic        pre;
    } exp_t;

    exp_t        q[$];
    int          cyc   = 0;
    int          nvec  = 0;
    int          nfail = 0;
    logic [15:0] wpm   = WPM;

    // Requester state: index 0 = CPU, 1 = a1, 2 = a2
    logic        v[3];
    logic [3:0]  ra[3];
    logic [15:0] rd[3];
    bit          acc[3];
    int          cnt[3];
    int          rr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endfunction

    // Reference: starving aux first, then CPU, then round-robin among aux.
    function automatic int model_grant(output bit pre);
        bit s1;
        bit s2;
        s1  = (LIMIT != 0) && v[1] && (cnt[1] >= LIMIT);
        s2  = (LIMIT != 0) && v[2] && (cnt[2] >= LIMIT);
        pre = s1 || s2;
        if (s1 && s2) return rr;
        if (s1) return 1;
        if (s2) return 2;
        if (v[0]) return 0;
        if (v[1] && v[2]) return rr;
        if (v[1]) return 1;
        if (v[2]) return 2;
        return -1;
    endfunction

    task automatic drive_cycle();
        bit         pre;
        int         g;
        logic [2:0] er;
        logic       en;
        logic       wp;
        logic [3:0] a;
        exp_t       e;
        @(negedge clk);
        bus.cpu_valid = v[0]; bus.cpu_addr = ra[0]; bus.cpu_data = rd[0];
        bus.a1_valid  = v[1]; bus.a1_addr  = ra[1]; bus.a1_data  = rd[1];
        bus.a2_valid  = v[2]; bus.a2_addr  = ra[2]; bus.a2_data  = rd[2];
        #1;
        g  = model_grant(pre);
        er = 3'b000;
        if (g >= 0) er[g] = 1'b1;
        check("ready", {29'd0, bus.a2_ready, bus.a1_ready, bus.cpu_ready}, {29'd0, er});
        acc = '{0, 0, 0};
        if (g >= 0) begin
            acc[g] = 1;
            a  = ra[g];
            wp = (g > 0) && (a != 4'd0) && wpm[a];
            en = (a != 4'd0) && !((g > 0) && wpm[a]);
            if (en || wp || (pre && v[0])) begin
                e.cyc = cyc + 1; e.en = en; e.a = a; e.d = rd[g];
                e.wp = wp; e.pre = pre && v[0];
                q.push_back(e);
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (g == i || !v[i]) cnt[i] = 0;
            else if (cnt[i] < (2 ** SWB) - 1) cnt[i]++;
        end
        if (g > 0) rr = (g == 1) ? 2 : 1;
    endtask

    task automatic set_req(int i, logic vv, logic [3:0] aa, logic [15:0] dd);
        v[i] = vv; ra[i] = aa; rd[i] = dd;
    endtask

    task automatic rand_reqs(int pc, int pa);
        for (int i = 0; i < 3; i++) begin
            if (!(v[i] && !acc[i])) begin
                v[i]  = ($urandom_range(0, 99) < ((i == 0) ? pc : pa));
                ra[i] = 4'($urandom_range(0, 15));
                rd[i] = 16'($urandom);
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        repeat (n) drive_cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    nvec++; nfail++;
                    $display("FAIL missing_write cyc=%0d got none exp addr=%0h data=%0h due cyc %0d",
                             cyc, q[0].a, q[0].d, q[0].cyc);
                    void'(q.pop_front());
                end
                if (bus.wr_en || bus.wp_err || bus.starve_pre) begin
                    if (q.size() == 0) begin
                        nvec++; nfail++;
                        $display("FAIL unexpected_out cyc=%0d got en=%b wp=%b pre=%b addr=%0h exp none",
                                 cyc, bus.wr_en, bus.wp_err, bus.starve_pre, bus.wr_addr);
                    end else begin
                        e = q.pop_front();
                        check("out_cycle",  cyc,            e.cyc);
                        check("wr_en",      bus.wr_en,      e.en);
                        check("wr_addr",    bus.wr_addr,    e.a);
                        check("wr_data",    bus.wr_data,    e.d);
                        check("wp_err",     bus.wp_err,     e.wp);
                        check("starve_pre", bus.starve_pre, e.pre);
                    end
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; ra[i] = 4'd0; rd[i] = 16'd0; acc[i] = 0; cnt[i] = 0;
        end
        rr = 1;
        bus.cpu_valid = 1'b0; bus.cpu_addr = 4'd0; bus.cpu_data = 16'd0;
        bus.a1_valid  = 1'b0; bus.a1_addr  = 4'd0; bus.a1_data  = 16'd0;
        bus.a2_valid  = 1'b0; bus.a2_addr  = 4'd0; bus.a2_data  = 16'd0;
`ifdef REG_WR_ARB_STATS_EN
        bus.stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        bus.cpu_valid = 1'b1; bus.a1_valid = 1'b1; bus.a2_valid = 1'b1;
        #1;
        check("rst_ready",      {bus.a2_ready, bus.a1_ready, bus.cpu_ready}, 3'b000);
        check("rst_wr_en",      bus.wr_en,      1'b0);
        check("rst_wr_addr",    bus.wr_addr,    4'd0);
        check("rst_wr_data",    bus.wr_data,    16'd0);
        check("rst_wp_err",     bus.wp_err,     1'b0);
        check("rst_starve_pre", bus.starve_pre, 1'b0);
        bus.cpu_valid = 1'b0; bus.a1_valid = 1'b0; bus.a2_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single CPU write
        set_req(0, 1'b1, 4'd5, 16'hBEEF);
        drive_cycle();
        idle(3);

        // Both aux busy, CPU idle: alternation
        set_req(1, 1'b1, 4'd9, 16'h0101);
        set_req(2, 1'b1, 4'd10, 16'h0202);
        repeat (6) begin
            drive_cycle();
            for (int i = 1; i < 3; i++) if (acc[i]) rd[i] = 16'($urandom);
        end
        idle(2);

        // CPU saturating the port while a1 waits
        set_req(0, 1'b1, 4'd4, 16'h4000);
        set_req(1, 1'b1, 4'd9, 16'h1111);
        repeat (12) begin
            drive_cycle();
            if (acc[0]) rd[0] = 16'($urandom);
            if (acc[1]) v[1] = 1'b0;
        end
        idle(2);

        // Hard-zero register and write protection
        set_req(2, 1'b1, 4'd0, 16'h0A0A); drive_cycle(); idle(1);
        set_req(2, 1'b1, 4'd3, 16'h3333); drive_cycle(); idle(1);
        set_req(0, 1'b1, 4'd3, 16'h4444); drive_cycle(); idle(2);

        // Reset while a write sits in the output stage; pointer left at a2
        set_req(1, 1'b1, 4'd7, 16'h7777);
        drive_cycle();
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        bus.cpu_valid = 1'b1; bus.a1_valid = 1'b1; bus.a2_valid = 1'b1;
        #1;
        check("midrst_wr_en", bus.wr_en, 1'b0);
        check("midrst_ready", {bus.a2_ready, bus.a1_ready, bus.cpu_ready}, 3'b000);
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; acc[i] = 0; end
        rr = 1;
        repeat (2) @(negedge clk);
        bus.cpu_valid = 1'b0; bus.a1_valid = 1'b0; bus.a2_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        set_req(1, 1'b1, 4'd9, 16'h9999);
        set_req(2, 1'b1, 4'd10, 16'hAAAA);
        drive_cycle();
        check("post_rst_a1_first", acc[1], 1'b1);
        idle(2);

`ifdef REG_WR_ARB_STATS_EN
        @(negedge clk); bus.stat_clr = 1'b1;
        @(posedge clk); #1 bus.stat_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin set_req(0, 1'b1, 4'd1, 16'(k)); drive_cycle(); idle(1); end
        for (int k = 0; k < 2; k++) begin set_req(1, 1'b1, 4'd8, 16'(k)); drive_cycle(); idle(1); end
        set_req(2, 1'b1, 4'd12, 16'h00C0); drive_cycle(); idle(2);
        check("stat_cpu", bus.stat_cpu, 16'd3);
        check("stat_a1",  bus.stat_a1,  16'd2);
        check("stat_a2",  bus.stat_a2,  16'd1);
        check("stat_pre", bus.stat_pre, 16'd0);
        @(negedge clk); bus.stat_clr = 1'b1;
        @(posedge clk); #1 bus.stat_clr = 1'b0;
        check("stat_clr", {bus.stat_cpu, bus.stat_a1}, 32'd0);
        check("stat_clr2", {bus.stat_a2, bus.stat_pre}, 32'd0);
`endif

        // Randomized traffic: light load, heavy CPU load, everyone saturated
        repeat (300) begin rand_reqs(30, 40); drive_cycle(); end
        repeat (300) begin rand_reqs(90, 60); drive_cycle(); end
        repeat (300) begin rand_reqs(97, 95); drive_cycle(); end
        idle(3);

        nvec++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

`default_nettype wire
